// File: rtl/cfg_deserializer_if.sv
// Byte-stream and register-write signals between a config byte source and cfg_deserializer.
// master = stream source / write observer, slave = the deserializer.
interface cfg_deserializer_if #(
  parameter int MEM_WIDTH   = 24,
  parameter int DATA_WIDTH  = 8,
  parameter int WORD_NUMBER = 326
);
  localparam int ADDR_WIDTH = MEM_WIDTH - DATA_WIDTH;
  localparam int CNT_WIDTH  = $clog2(WORD_NUMBER + 1);

  logic                  strb_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  ack_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic [CNT_WIDTH-1:0]  word_cnt_o;
  logic                  done_o;
  logic                  addr_err_o;
  logic                  proto_err_o;
  logic                  timeout_o;

  modport master (
    output strb_i, data_i,
    input  ack_o, wr_en_o, wr_addr_o, wr_data_o, word_cnt_o,
    input  done_o, addr_err_o, proto_err_o, timeout_o
  );

  modport slave (
    input  strb_i, data_i,
    output ack_o, wr_en_o, wr_addr_o, wr_data_o, word_cnt_o,
    output done_o, addr_err_o, proto_err_o, timeout_o
  );
endinterface

// File: rtl/cfg_deserializer.sv
// Device-side receiver of the config byte stream: checks the slave address, rebuilds words MSB byte
// first and emits each as one register write. Define TIMEOUT_EN to enable the intra-word gap timeout.
module cfg_deserializer #(
  parameter int                    MEM_WIDTH      = 24,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    WORD_NUMBER    = 326,
  parameter logic [DATA_WIDTH-1:0] SLAVE_ADDR     = 8'b11101000,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  cfg_deserializer_if.slave   bus
);
  localparam int CYCLES     = MEM_WIDTH / DATA_WIDTH;
  localparam int ADDR_WIDTH = MEM_WIDTH - DATA_WIDTH;
  localparam int CNT_WIDTH  = $clog2(WORD_NUMBER + 1);
  localparam int BCNT_W     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  if ((MEM_WIDTH % DATA_WIDTH) != 0 || MEM_WIDTH <= DATA_WIDTH || TIMEOUT_CYCLES < 1)
  begin : g_badParams
    $error("cfg_deserializer: MEM_WIDTH must be a multiple (>1) of DATA_WIDTH, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_SLV,
    ST_BYTE,
    ST_WRITE
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [BCNT_W-1:0]     r_byteCnt;
  logic [BCNT_W-1:0]     w_byteCntNext;
  logic [ADDR_WIDTH-1:0] r_shift;
  logic [ADDR_WIDTH-1:0] w_shiftNext;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [DATA_WIDTH-1:0] r_wrData;
  logic [CNT_WIDTH-1:0]  r_wordCnt;
  logic [CNT_WIDTH-1:0]  w_wordCntNext;
  logic                  r_ack;
  logic                  r_addrErr;
  logic                  r_protoErr;
  logic                  r_timeout;
  logic                  w_ack;
  logic                  w_addrErr;
  logic                  w_protoErr;
  logic                  w_timeout;
  logic                  w_load;
  logic                  w_lastByte;
  logic                  w_passDone;
  logic                  w_expire;
  logic [MEM_WIDTH-1:0]  w_word;

  // Only the bytes already received need storing; the incoming byte completes the word.
  assign w_word     = {r_shift, bus.data_i};
  assign w_lastByte = (r_byteCnt == BCNT_W'(CYCLES - 1));
  assign w_passDone = (r_wordCnt == CNT_WIDTH'(WORD_NUMBER));

`ifdef TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] r_gap;
  logic             w_gapRun;

  // A strobe on the expiry cycle suppresses the expiry, so the byte wins.
  assign w_gapRun = (r_state == ST_BYTE) && (r_byteCnt != '0) && !bus.strb_i;
  assign w_expire = w_gapRun && (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_gap <= '0;
    end else if (!w_gapRun || w_expire) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= ST_SLV;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_byteCntNext = r_byteCnt;
    w_shiftNext   = r_shift;
    w_wordCntNext = r_wordCnt;
    w_ack         = 1'b0;
    w_addrErr     = 1'b0;
    w_protoErr    = 1'b0;
    w_timeout     = 1'b0;
    w_load        = 1'b0;
    unique case (r_state)
      ST_SLV: begin
        if (bus.strb_i) begin
          if (bus.data_i == SLAVE_ADDR) begin
            w_ack         = 1'b1;
            w_byteCntNext = '0;
            w_nextState   = ST_BYTE;
          end else begin
            w_addrErr = 1'b1;
          end
        end
      end
      ST_BYTE: begin
        if (bus.strb_i) begin
          w_ack       = 1'b1;
          w_shiftNext = w_word[ADDR_WIDTH-1:0];
          if (w_lastByte) begin
            w_load        = 1'b1;
            w_wordCntNext = r_wordCnt + CNT_WIDTH'(1);
            w_byteCntNext = '0;
            w_nextState   = ST_WRITE;
          end else begin
            w_byteCntNext = r_byteCnt + BCNT_W'(1);
          end
        end else if (w_expire) begin
          w_timeout     = 1'b1;
          w_byteCntNext = '0;
          w_shiftNext   = '0;
        end
      end
      ST_WRITE: begin
        // The write cycle cannot take a byte; flag it and carry on as if it never came.
        w_protoErr = bus.strb_i;
        if (w_passDone) begin
          w_wordCntNext = '0;
          w_nextState   = ST_SLV;
        end else begin
          w_byteCntNext = '0;
          w_nextState   = ST_BYTE;
        end
      end
      default: begin
        w_nextState = ST_SLV;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_byteCnt  <= '0;
      r_shift    <= '0;
      r_wordCnt  <= '0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
      r_ack      <= 1'b0;
      r_addrErr  <= 1'b0;
      r_protoErr <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_byteCnt  <= w_byteCntNext;
      r_shift    <= w_shiftNext;
      r_wordCnt  <= w_wordCntNext;
      r_ack      <= w_ack;
      r_addrErr  <= w_addrErr;
      r_protoErr <= w_protoErr;
      r_timeout  <= w_timeout;
      if (w_load) begin
        r_wrAddr <= w_word[MEM_WIDTH-1:DATA_WIDTH];
        r_wrData <= w_word[DATA_WIDTH-1:0];
      end
    end
  end

  assign bus.ack_o       = r_ack;
  assign bus.wr_en_o     = (r_state == ST_WRITE);
  assign bus.wr_addr_o   = r_wrAddr;
  assign bus.wr_data_o   = r_wrData;
  assign bus.word_cnt_o  = r_wordCnt;
  assign bus.done_o      = (r_state == ST_WRITE) && w_passDone;
  assign bus.addr_err_o  = r_addrErr;
  assign bus.proto_err_o = r_protoErr;
  assign bus.timeout_o   = r_timeout;
endmodule

// File: tb/tb_cfg_deserializer.sv
// Self-checking bench for cfg_deserializer: a byte-queue model checked every cycle plus
// directed vectors with literal expectations; the timeout vector runs when TIMEOUT_EN is defined.
module tb_cfg_deserializer;
  localparam int         MW = 24;
  localparam int         DW = 8;
  localparam int         WN = 3;
  localparam int         TO = 16;
  localparam logic [7:0] SA = 8'hE8;
  localparam int         NB = MW / DW;

  logic clk;
  logic arstn;
  int   checks = 0;
  int   errors = 0;

  cfg_deserializer_if #(.MEM_WIDTH(MW), .DATA_WIDTH(DW), .WORD_NUMBER(WN)) bus ();

  cfg_deserializer #(
    .MEM_WIDTH(MW), .DATA_WIDTH(DW), .WORD_NUMBER(WN),
    .SLAVE_ADDR(SA), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .arstn_i(arstn),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: header flag, queue of bytes of the current word, words so far in this pass
  bit               mInPass = 1'b0;
  bit               mWriting = 1'b0;
  logic [DW-1:0]    mBytes[$];
  int               mWordCnt = 0;
  logic [MW-1:0]    mWord;
`ifdef TIMEOUT_EN
  int               mGap = 0;
`endif
  logic             eAck = 1'b0, eWrEn = 1'b0, eDone = 1'b0;
  logic             eAddrErr = 1'b0, eProtoErr = 1'b0, eTimeout = 1'b0;
  logic [MW-DW-1:0] eAddr = '0;
  logic [DW-1:0]    eData = '0;
  int               eCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      mInPass = 1'b0; mWriting = 1'b0; mBytes.delete(); mWordCnt = 0;
`ifdef TIMEOUT_EN
      mGap = 0;
`endif
      eAck = 1'b0; eWrEn = 1'b0; eDone = 1'b0; eAddrErr = 1'b0; eProtoErr = 1'b0;
      eTimeout = 1'b0; eAddr = '0; eData = '0; eCnt = 0;
    end else begin
      eAck = 1'b0; eWrEn = 1'b0; eDone = 1'b0;
      eAddrErr = 1'b0; eProtoErr = 1'b0; eTimeout = 1'b0;
      if (mWriting) begin
        mWriting = 1'b0;
        if (bus.strb_i) eProtoErr = 1'b1;
        if (mWordCnt == WN) begin
          mWordCnt = 0;
          mInPass  = 1'b0;
        end
      end else if (bus.strb_i) begin
        if (!mInPass) begin
          if (bus.data_i == SA) begin
            eAck = 1'b1;
            mInPass = 1'b1;
            mBytes.delete();
          end else begin
            eAddrErr = 1'b1;
          end
        end else begin
          eAck = 1'b1;
          mBytes.push_back(bus.data_i);
`ifdef TIMEOUT_EN
          mGap = 0;
`endif
          if (mBytes.size() == NB) begin
            mWord = '0;
            foreach (mBytes[i]) mWord = (mWord << DW) | MW'(mBytes[i]);
            eAddr = mWord[MW-1:DW];
            eData = mWord[DW-1:0];
            mWordCnt++;
            mWriting = 1'b1;
            eWrEn = 1'b1;
            eDone = (mWordCnt == WN);
            mBytes.delete();
          end
        end
      end
`ifdef TIMEOUT_EN
      else if (mInPass && mBytes.size() > 0) begin
        mGap++;
        if (mGap == TO) begin
          eTimeout = 1'b1;
          mBytes.delete();
          mGap = 0;
        end
      end
`endif
      eCnt = mWordCnt;
    end
  end

  always @(negedge clk) begin
    checkOutput("ack_o", 32'(bus.ack_o), 32'(eAck));
    checkOutput("wr_en_o", 32'(bus.wr_en_o), 32'(eWrEn));
    checkOutput("wr_addr_o", 32'(bus.wr_addr_o), 32'(eAddr));
    checkOutput("wr_data_o", 32'(bus.wr_data_o), 32'(eData));
    checkOutput("word_cnt_o", 32'(bus.word_cnt_o), 32'(eCnt));
    checkOutput("done_o", 32'(bus.done_o), 32'(eDone));
    checkOutput("addr_err_o", 32'(bus.addr_err_o), 32'(eAddrErr));
    checkOutput("proto_err_o", 32'(bus.proto_err_o), 32'(eProtoErr));
    checkOutput("timeout_o", 32'(bus.timeout_o), 32'(eTimeout));
  end

  // One-cycle strobe; returns on the falling edge after the capture edge and checks the ack there.
  task automatic applyStimulus(input logic [7:0] b, input bit expAck);
    @(posedge clk);
    #1 bus.strb_i = 1'b1;
    bus.data_i = b;
    @(posedge clk);
    #1 bus.strb_i = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("lit_ack_%02h", b), 32'(bus.ack_o), 32'(expAck));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkWrite(input logic [15:0] addr, input logic [7:0] data, input int cnt, input bit done);
    checkOutput("lit_wr_en", 32'(bus.wr_en_o), 32'd1);
    checkOutput("lit_wr_addr", 32'(bus.wr_addr_o), 32'(addr));
    checkOutput("lit_wr_data", 32'(bus.wr_data_o), 32'(data));
    checkOutput("lit_word_cnt", 32'(bus.word_cnt_o), 32'(cnt));
    checkOutput("lit_done", 32'(bus.done_o), 32'(done));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    bus.strb_i = 1'b0;
    bus.data_i = '0;
    arstn = 1'b1;
    #1 arstn = 1'b0;
    idle(3);
    checkOutput("lit_reset_wr_en", 32'(bus.wr_en_o), 32'd0);
    checkOutput("lit_reset_word_cnt", 32'(bus.word_cnt_o), 32'd0);
    checkOutput("lit_reset_ack", 32'(bus.ack_o), 32'd0);
    #2 arstn = 1'b1;

    $display("[TB] wrong slave address, then correct one");
    applyStimulus(8'hE9, 1'b0);
    checkOutput("lit_addr_err", 32'(bus.addr_err_o), 32'd1);
    applyStimulus(8'hE8, 1'b1);

    $display("[TB] first word with 5-cycle gaps");
    idle(5); applyStimulus(8'h00, 1'b1);
    idle(5); applyStimulus(8'h0B, 1'b1);
    idle(5); applyStimulus(8'h24, 1'b1);
    checkWrite(16'h000B, 8'h24, 1, 1'b0);
    idle(1);
    checkOutput("lit_wr_en_drop", 32'(bus.wr_en_o), 32'd0);

    $display("[TB] second word with a strobe during the write cycle");
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h56, 1'b1);
    checkWrite(16'h1234, 8'h56, 2, 1'b0);
    bus.strb_i = 1'b1;
    bus.data_i = 8'hFF;
    @(posedge clk);
    #1 bus.strb_i = 1'b0;
    @(negedge clk);
    checkOutput("lit_proto_err", 32'(bus.proto_err_o), 32'd1);
    checkOutput("lit_proto_no_ack", 32'(bus.ack_o), 32'd0);

    $display("[TB] third word completes the pass");
    applyStimulus(8'hAB, 1'b1);
    applyStimulus(8'hCD, 1'b1);
    applyStimulus(8'hEF, 1'b1);
    checkWrite(16'hABCD, 8'hEF, 3, 1'b1);
    idle(1);
    checkOutput("lit_cnt_wrap", 32'(bus.word_cnt_o), 32'd0);
    applyStimulus(8'hE8, 1'b1);

    $display("[TB] idle gap inside a word");
    applyStimulus(8'h01, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.timeout_o) pulses++;
    end
`ifdef TIMEOUT_EN
    checkOutput("lit_timeout_pulses", 32'(pulses), 32'd1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h0B, 1'b1);
    applyStimulus(8'h24, 1'b1);
    checkWrite(16'h000B, 8'h24, 1, 1'b0);
`else
    checkOutput("lit_timeout_pulses", 32'(pulses), 32'd0);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h0B, 1'b1);
    checkWrite(16'h0100, 8'h0B, 1, 1'b0);
    applyStimulus(8'h24, 1'b1);
`endif

    $display("[TB] reset in the middle of a word");
    applyStimulus(8'h77, 1'b1);
    applyStimulus(8'h88, 1'b1);
    #2 arstn = 1'b0;
    idle(2);
    checkOutput("lit_midreset_wr_en", 32'(bus.wr_en_o), 32'd0);
    checkOutput("lit_midreset_addr", 32'(bus.wr_addr_o), 32'd0);
    checkOutput("lit_midreset_data", 32'(bus.wr_data_o), 32'd0);
    checkOutput("lit_midreset_cnt", 32'(bus.word_cnt_o), 32'd0);
    #2 arstn = 1'b1;
    applyStimulus(8'h12, 1'b0);
    checkOutput("lit_post_reset_addr_err", 32'(bus.addr_err_o), 32'd1);
    applyStimulus(8'hE8, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h03, 1'b1);
    checkWrite(16'h0102, 8'h03, 1, 1'b0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
